// File: rtl/sw_hex_display_if.sv
// Board-side signal bundle for sw_hex_display: raw switches in, segments and LEDs out.
// master = board/bench side, slave = display logic side.
interface sw_hex_display_if #(
  parameter int NUM_DIGITS = 6
);
  logic [9:0]              SW;
  logic [8*NUM_DIGITS-1:0] HEX;
  logic [9:0]              LEDR;

  modport master (output SW, input HEX, input LEDR);
  modport slave  (input SW, output HEX, output LEDR);
endinterface

// File: rtl/sw_hex_display.sv
// Debounced slide switches feeding a shift-in hex digit store on seven-segment displays.
// Optional cursor blink on digit 0 is compiled in with SW_HEX_DISPLAY_BLINK_EN.

// Per-switch lane: 2-flop synchronizer followed by a consecutive-mismatch debounce counter.
module sw_hex_debounce #(
  parameter int DB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);
  localparam int CW = (DB_CYCLES < 2) ? 1 : $clog2(DB_CYCLES + 1);

  logic          sync1, sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      dout  <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      if (sync2 == dout) begin
        cnt <= '0;
      end else if (cnt == CW'(DB_CYCLES - 1)) begin
        cnt  <= '0;
        dout <= sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module sw_hex_display #(
  parameter int NUM_DIGITS = 6,
  parameter int DB_CYCLES  = 500000,
  parameter int BLINK_HALF = 25000000
) (
  input  logic              MAX10_CLK1_50,
  input  logic              RST,
  sw_hex_display_if.slave   io
);
  generate
    if (NUM_DIGITS < 1 || NUM_DIGITS > 6) begin : g_bad_digits
      $error("sw_hex_display: NUM_DIGITS must be 1..6");
    end
    if (DB_CYCLES < 1 || BLINK_HALF < 1) begin : g_bad_timing
      $error("sw_hex_display: DB_CYCLES and BLINK_HALF must be >= 1");
    end
  endgenerate

  logic [9:0]                       sw_db;
  logic                             ld_prev;
  logic                             load;
  logic                             raw_mode;
  logic                             blank;
  logic [NUM_DIGITS-1:0][3:0]       digits;
  logic [NUM_DIGITS-1:0][7:0]       hex_nxt;
  logic [NUM_DIGITS-1:0][7:0]       hex_q;

  for (genvar i = 0; i < 10; i++) begin : g_lane
    sw_hex_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
      .clk  (MAX10_CLK1_50),
      .rst  (RST),
      .din  (io.SW[i]),
      .dout (sw_db[i])
    );
  end

  // Load strobe on the debounced rising edge of SW[9] only.
  always_ff @(posedge MAX10_CLK1_50) begin
    if (RST) ld_prev <= 1'b0;
    else     ld_prev <= sw_db[9];
  end

  assign load     = sw_db[9] & ~ld_prev;
  assign raw_mode = sw_db[8];

  always_ff @(posedge MAX10_CLK1_50) begin
    if (RST) begin
      digits <= '0;
    end else if (load) begin
      for (int k = NUM_DIGITS - 1; k >= 1; k--) digits[k] <= digits[k-1];
      digits[0] <= sw_db[3:0];
    end
  end

`ifdef SW_HEX_DISPLAY_BLINK_EN
  localparam int BW = (BLINK_HALF < 2) ? 1 : $clog2(BLINK_HALF + 1);
  logic [BW-1:0] blink_cnt;

  // Phase restarts visible on every load so a freshly entered digit is seen at once.
  always_ff @(posedge MAX10_CLK1_50) begin
    if (RST || load) begin
      blink_cnt <= '0;
      blank     <= 1'b0;
    end else if (blink_cnt == BW'(BLINK_HALF - 1)) begin
      blink_cnt <= '0;
      blank     <= ~blank;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end
`else
  assign blank = 1'b0;
`endif

  function automatic logic [7:0] seg7(input logic [3:0] n);
    logic [7:0] s;
    case (n)
      4'h0: s = 8'hC0;
      4'h1: s = 8'hF9;
      4'h2: s = 8'hA4;
      4'h3: s = 8'hB0;
      4'h4: s = 8'h99;
      4'h5: s = 8'h92;
      4'h6: s = 8'h82;
      4'h7: s = 8'hF8;
      4'h8: s = 8'h80;
      4'h9: s = 8'h90;
      4'hA: s = 8'h88;
      4'hB: s = 8'h83;
      4'hC: s = 8'hC6;
      4'hD: s = 8'hA1;
      4'hE: s = 8'h86;
      default: s = 8'h8E;
    endcase
    return s;
  endfunction

  always_comb begin
    hex_nxt = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (raw_mode) begin
        if (k == 0) hex_nxt[k] = sw_db[7:0];
      end else if (!(k == 0 && blank)) begin
        hex_nxt[k] = seg7(digits[k]);
      end
    end
  end

  always_ff @(posedge MAX10_CLK1_50) begin
    if (RST) hex_q <= '1;
    else     hex_q <= hex_nxt;
  end

  assign io.HEX  = hex_q;
  assign io.LEDR = sw_db;
endmodule

// File: tb/tb_sw_hex_display.sv
// Scoreboard bench for sw_hex_display (NUM_DIGITS=4, DB_CYCLES=4, BLINK_HALF=8).
// Expected values are queued as stimulus is applied and popped once outputs settle.
module tb_sw_hex_display;
  localparam int ND = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_pass = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
    bit          led;
  } exp_t;
  exp_t sb[$];

  sw_hex_display_if #(.NUM_DIGITS(ND)) io ();

  sw_hex_display #(.NUM_DIGITS(ND), .DB_CYCLES(4), .BLINK_HALF(8)) dut (
    .MAX10_CLK1_50 (clk),
    .RST           (rst),
    .io            (io)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_hex(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag; e.val = v; e.led = 1'b0;
    sb.push_back(e);
  endtask

  task automatic push_led(input string tag, input logic [9:0] v);
    exp_t e;
    e.tag = tag; e.val = {22'b0, v}; e.led = 1'b1;
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_underflow", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk(e.tag, e.led ? {22'b0, io.LEDR} : io.HEX, e.val);
    end
  endtask

  task automatic do_load(input logic [3:0] n, input string tag, input logic [31:0] v);
    io.SW[3:0] = n;
    tick(8);
    push_hex(tag, v);
    io.SW[9] = 1'b1;
    tick(10);
    io.SW[9] = 1'b0;
    tick(10);
    pop_check();
  endtask

  task automatic wait_d0(input logic [7:0] v, input string tag);
    bit found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick(1);
      if (io.HEX[7:0] == v) found = 1'b1;
    end
    chk(tag, {31'b0, found}, 32'd1);
  endtask

  initial begin
    io.SW = '0;
    rst   = 1'b1;
    push_hex("rst_hex", 32'hFFFF_FFFF);
    push_led("rst_led", 10'h000);
    tick(3);
    pop_check();
    pop_check();
    push_hex("rel_hex", 32'hC0C0_C0C0);
    rst = 1'b0;
    tick(1);
    pop_check();

`ifdef SW_HEX_DISPLAY_BLINK_EN
    io.SW[3:0] = 4'h7;
    tick(8);
    io.SW[9] = 1'b1;
    wait_d0(8'hF8, "blink_first_on");
    chk("blink_upper", {8'h0, io.HEX[31:8]}, 32'h00C0_C0C0);
    push_hex("blink_on_end",  32'hC0C0_C0F8);
    push_hex("blink_off_beg", 32'hC0C0_C0FF);
    push_hex("blink_off_end", 32'hC0C0_C0FF);
    push_hex("blink_on_again", 32'hC0C0_C0F8);
    tick(7); pop_check();
    tick(1); pop_check();
    tick(7); pop_check();
    tick(1); pop_check();
    io.SW[9]   = 1'b0;
    io.SW[3:0] = 4'h2;
    tick(13);
    io.SW[9] = 1'b1;
    wait_d0(8'hA4, "reload_on");
    push_hex("reload_on_end", 32'hC0C0_F8A4);
    push_hex("reload_off",    32'hC0C0_F8FF);
    tick(7); pop_check();
    tick(1); pop_check();
    tick(3);
    push_hex("blink_rst", 32'hFFFF_FFFF);
    rst = 1'b1;
    tick(1);
    pop_check();
    rst = 1'b0;
`else
    // Glitch shorter than the window, then a held edge with exact latency.
    push_led("glitch", 10'h000);
    io.SW[0] = 1'b1;
    tick(3);
    io.SW[0] = 1'b0;
    tick(12);
    pop_check();
    push_led("db_early", 10'h000);
    push_led("db_exact", 10'h001);
    io.SW[0] = 1'b1;
    tick(5); pop_check();
    tick(1); pop_check();

    do_load(4'hA, "load_a", 32'hC0C0_C088);
    do_load(4'h3, "load_3", 32'hC0C0_88B0);
    do_load(4'h1, "load_1", 32'hC088_B0F9);
    do_load(4'h2, "load_2", 32'h88B0_F9A4);
    do_load(4'h3, "load_3b", 32'hB0F9_A4B0);
    do_load(4'h4, "load_4", 32'hF9A4_B099);
    do_load(4'h5, "load_5", 32'hA4B0_9992);

    push_hex("noload_hex", 32'hA4B0_9992);
    push_led("noload_led", 10'h00C);
    io.SW[3:0] = 4'hC;
    tick(12);
    pop_check();
    pop_check();

    push_hex("raw_hex", 32'hFFFF_FFA5);
    push_led("raw_led", 10'h1A5);
    io.SW = 10'h1A5;
    tick(12);
    pop_check();
    pop_check();
    push_hex("hex_restore", 32'hA4B0_9992);
    io.SW[8] = 1'b0;
    tick(12);
    pop_check();

    // SW[9] held through reset must reload exactly once after re-qualifying.
    io.SW = 10'h207;
    tick(12);
    push_hex("hold_rst_hex", 32'hFFFF_FFFF);
    rst = 1'b1;
    tick(3);
    pop_check();
    push_hex("hold_rel_hex", 32'hC0C0_C0C0);
    push_led("hold_rel_led", 10'h000);
    rst = 1'b0;
    tick(1);
    pop_check();
    pop_check();
    push_led("hold_ledr", 10'h207);
    push_hex("hold_one_load", 32'hC0C0_C0F8);
    tick(12);
    pop_check();
    pop_check();
    push_hex("hold_no_second", 32'hC0C0_C0F8);
    tick(20);
    pop_check();
    io.SW[9] = 1'b0;
    tick(10);
`endif

    if (sb.size() != 0) chk("sb_leftover", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/sw_hex_display.md
SW_HEX_DISPLAY -- requirements
Module: sw_hex_display

Interface
- REQ-001 SHALL have parameter NUM_DIGITS, default 6, number of seven-segment digits driven (legal 1..6).
- REQ-002 SHALL have parameter DB_CYCLES, default 500000, debounce stability window in clocks (10 ms at 50 MHz).
- REQ-003 SHALL have parameter BLINK_HALF, default 25000000, blink half-period in clocks (used only under REQ-027).
- REQ-004 SHALL have port MAX10_CLK1_50  input  1  the single clock; all state on its rising edge.
- REQ-005 SHALL have port RST  input  1  reset, synchronous and active-high.
- REQ-006 SHALL have port SW  input  10  raw asynchronous slide switches.
- REQ-007 SHALL have port HEX  output  8*NUM_DIGITS  segments, active-low; digit k on bits [8k+7:8k]; bit 7 of each digit is DP.
- REQ-008 SHALL have port LEDR  output  10  debounced switch state, registered.

Function
- REQ-009 SHALL pass each SW bit through a 2-flop synchronizer and then its own debounce counter.
- REQ-010 Debounce: a bit's stable value SHALL flip only after the synchronized value differs from it for DB_CYCLES consecutive clocks; the counter SHALL clear on any cycle they match. Latency SW edge -> LEDR = 2 + DB_CYCLES clocks.
- REQ-011 A glitch shorter than DB_CYCLES clocks SHALL produce no LEDR change.
- REQ-012 Debounced SW[9] rising edge SHALL produce a one-cycle load pulse; falling edges SHALL produce none.
- REQ-013 On a load pulse the digit store SHALL shift: digit[k] <= digit[k-1] for k = NUM_DIGITS-1..1, digit[0] <= debounced SW[3:0]; the oldest digit is discarded.
- REQ-014 Debounced SW[8] SHALL select mode: 0 = hex, 1 = raw.
- REQ-015 Hex mode: digit k SHALL show the decoded nibble, DP off: 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90 A=88 b=83 C=C6 d=A1 E=86 F=8E (hex values, bits 7..0).
- REQ-016 Raw mode: HEX[7:0] SHALL equal debounced SW[7:0] bit-for-bit; all other digits SHALL be FF (blank).
- REQ-017 Load pulses SHALL be accepted in both modes; the store is unaffected by a mode change.
- REQ-018 HEX SHALL be registered: it reflects the store/mode one clock after they change.
- REQ-019 Store and HEX SHALL be unaffected by SW[3:0] changes without a load pulse.

Reset
- REQ-020 While RST is high at a clock edge: all digits 0, all debounce stable values and counters 0, synchronizers 0, load-edge history 0, LEDR = 000, HEX = all FF.
- REQ-021 RST SHALL take priority over a simultaneous load pulse or debounce flip.
- REQ-022 First clock after RST deasserts: HEX = C0 on every digit (hex mode, store 0).
- REQ-023 A debounce in progress at reset SHALL be abandoned; a switch held high through reset re-qualifies over a full 2 + DB_CYCLES window afterwards.
- REQ-024 A switch SW[9] held high through reset SHALL generate one load pulse after it qualifies.

Configuration
- REQ-025 Macro SW_HEX_DISPLAY_BLINK_EN SHALL compile a cursor-blink feature in or out.
- REQ-026 Without the macro: no blink counter exists; digit 0 is steady.
- REQ-027 With the macro: in hex mode only, digit 0 SHALL show its decoded value for BLINK_HALF clocks then FF for BLINK_HALF clocks, repeating; the counter SHALL reset to the visible phase on RST and on every load pulse; raw mode is never blanked.

Verification (bench uses NUM_DIGITS=4, DB_CYCLES=4, BLINK_HALF=8)
- REQ-028 RST high 3 clocks, release -> HEX = FFFFFFFF during reset, C0C0C0C0 one clock after release, LEDR = 000.
- REQ-029 SW[3:0]=A, pulse SW[9] high 10 clocks; then SW[3:0]=3, pulse again -> HEX = C0C088B0 (digit1=A, digit0=3).
- REQ-030 Five loads of 1,2,3,4,5 -> HEX = F9A4B099 after first four, A4B09992 after fifth (digit 1 discarded).
- REQ-031 SW[0] glitch high 3 clocks -> LEDR unchanged; held high 6 clocks -> LEDR[0]=1 exactly 6 clocks after SW edge.
- REQ-032 SW[8]=1, SW[7:0]=A5 -> HEX = FFFFFFA5 after debounce; SW[8]=0 -> prior digits restored.
- REQ-033 With SW_HEX_DISPLAY_BLINK_EN, load 7 -> digit0 F8 for 8 clocks, FF for 8 clocks, repeating; a new load restarts the visible phase; RST asserted mid-blink -> HEX all FF.
